// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 mux family.
// Imported by the arbiter and the mux top.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: first requester after `last`,
// scanning upward with wrap-around.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter int N  = 3,
  parameter int SW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  int idx;

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux_n_1.sv
// N-input registered mux with valid/ready per channel; the channel is
// chosen by select input (fixed mode) or by a round-robin arbiter.
module rr_mux_n_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N     = 3,
  parameter int MODE  = MODE_FIXED,
  parameter int SW    = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SW-1:0]      s,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_sel_q, out_sel_d;
  logic [SW-1:0]    last_q, last_d;

  logic             load;
  logic             rr_valid, fix_valid, gnt_valid;
  logic [SW-1:0]    rr_idx, gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  rr_arbiter_n #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req       (in_valid),
    .last      (last_q),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // A select outside 0..N-1 never matches, so it yields no grant.
  always_comb begin
    fix_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (s == SW'(i) && in_valid[i]) fix_valid = 1'b1;
    end
    if (MODE == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end else begin
      gnt_valid = fix_valid;
      gnt_idx   = s;
    end
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    load     = !out_valid_q || out_ready;
    in_ready = '0;
    if (rst_n && load && gnt_valid) in_ready = N'(1) << gnt_idx;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (load) begin
      out_valid_d = gnt_valid;
      if (gnt_valid) begin
        out_data_d = gnt_data;
        out_sel_d  = gnt_idx;
        if (MODE == MODE_RR) last_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_n_1.sv
// Bench for rr_mux_n_1: a fixed-select 3x3 instance and a round-robin
// 4x4 instance, each compared against a behavioural model.
module tb_rr_mux_n_1;

  localparam int N0 = 3;
  localparam int W0 = 3;
  localparam int N1 = 4;
  localparam int W1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]  s0 = '0;
  logic [2:0]  v0 = '0;
  logic [8:0]  d0 = '0;
  logic [2:0]  r0;
  logic        ov0;
  logic [2:0]  od0;
  logic [1:0]  os0;
  logic        ordy0 = 1'b1;

  logic [1:0]  s1 = '0;
  logic [3:0]  v1 = '0;
  logic [15:0] d1 = '0;
  logic [3:0]  r1;
  logic        ov1;
  logic [3:0]  od1;
  logic [1:0]  os1;
  logic        ordy1 = 1'b1;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic       f_valid;
  logic [2:0] f_data;
  logic [1:0] f_sel;
  logic       m_valid;
  logic [3:0] m_data;
  logic [1:0] m_sel;
  int         m_last;

  always #5 clk = ~clk;

  rr_mux_n_1 #(.WIDTH(W0), .N(N0), .MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .s(s0), .in_valid(v0), .in_data(d0),
    .in_ready(r0), .out_valid(ov0), .out_data(od0), .out_sel(os0),
    .out_ready(ordy0)
  );

  rr_mux_n_1 #(.WIDTH(W1), .N(N1), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .s(s1), .in_valid(v1), .in_data(d1),
    .in_ready(r1), .out_valid(ov1), .out_data(od1), .out_sel(os1),
    .out_ready(ordy1)
  );

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= N1; k++) begin
      if (v[(last + k) % N1]) return (last + k) % N1;
    end
    return -1;
  endfunction

  function automatic int fix_pick();
    if (s0 < 2'd3 && v0[s0]) return int'(s0);
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready1();
    int g;
    if (!rst_n || (m_valid && !ordy1)) return 4'b0;
    g = rr_pick(v1, m_last);
    return (g < 0) ? 4'b0 : 4'(1 << g);
  endfunction

  function automatic logic [2:0] exp_ready0();
    int g;
    if (!rst_n || (f_valid && !ordy0)) return 3'b0;
    g = fix_pick();
    return (g < 0) ? 3'b0 : 3'(1 << g);
  endfunction

  // Advance both models with the inputs present at this edge.
  task automatic tick();
    int g;
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_last = N1 - 1;
      f_valid = 0; f_data = 0; f_sel = 0;
    end else begin
      if (!m_valid || ordy1) begin
        g = rr_pick(v1, m_last);
        if (g >= 0) begin
          m_valid = 1; m_data = d1[g*4 +: 4];
          m_sel = 2'(g); m_last = g;
        end else m_valid = 0;
      end
      if (!f_valid || ordy0) begin
        g = fix_pick();
        if (g >= 0) begin
          f_valid = 1; f_data = d0[g*3 +: 3]; f_sel = 2'(g);
        end else f_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 0; v0 = 3'b111; d0 = 9'o210; v1 = 4'hF; d1 = 16'hDCBA;
    ordy0 = 1; ordy1 = 1; s0 = 0;
    repeat (2) begin
      tick();
      total_cnt++;
      if ({ov1, od1, os1, r1, ov0, od0, os0, r0} !== '0)
        $display("FAIL reset_state got=%b%h%h%b %b%h%h%b exp=all zero",
                 ov1, od1, os1, r1, ov0, od0, os0, r0);
      else pass_cnt++;
    end
    rst_n = 1;
    #1;
    total_cnt++;
    if (r1 !== 4'b0001) $display("FAIL reset_first_ready got=%b exp=0001", r1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({ov1, os1, od1} !== {1'b1, 2'd0, 4'hA})
      $display("FAIL reset_first_grant got=%b/%0d/%h exp=1/0/a", ov1, os1, od1);
    else pass_cnt++;
  endtask

  task automatic test_fixed_select();
    logic [2:0] ed;
    do_reset();
    v0 = 3'b111; d0 = {3'b010, 3'b001, 3'b000}; ordy0 = 1;
    for (int s = 0; s < 4; s++) begin
      s0 = 2'(s);
      #1;
      total_cnt++;
      if (r0 !== exp_ready0() || r0 !== ((s < 3) ? 3'(1 << s) : 3'b0))
        $display("FAIL fixed_ready s=%0d got=%b exp=%b", s, r0, exp_ready0());
      else pass_cnt++;
      tick();
      ed = (s < 3) ? 3'(s) : 3'b010;
      total_cnt++;
      if ({ov0, od0, os0} !== {f_valid, f_data, f_sel} ||
          {ov0, od0} !== {s < 3, ed})
        $display("FAIL fixed_out s=%0d got=%b/%b/%0d exp=%b/%b", s,
                 ov0, od0, os0, s < 3, ed);
      else pass_cnt++;
    end
  endtask

  task automatic test_rr_fair();
    do_reset();
    v1 = 4'hF; d1 = 16'hDCBA; ordy1 = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total_cnt++;
      if (r1 !== exp_ready1() || r1 !== 4'(1 << (i % 4)))
        $display("FAIL fair_ready i=%0d got=%b exp=%b", i, r1, exp_ready1());
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ov1, os1, od1} !== {1'b1, 2'(i % 4), 4'(10 + i % 4)} ||
          {os1, od1} !== {m_sel, m_data})
        $display("FAIL fair_out i=%0d got=%0d/%h exp=%0d/%h", i, os1, od1,
                 i % 4, 10 + i % 4);
      else pass_cnt++;
    end
  endtask

  task automatic test_rr_sparse();
    v1 = 4'b1010; d1 = 16'($urandom); ordy1 = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total_cnt++;
      if (r1 !== exp_ready1())
        $display("FAIL sparse_ready i=%0d got=%b exp=%b", i, r1, exp_ready1());
      else pass_cnt++;
      tick();
      total_cnt++;
      if (os1 !== ((i % 2 == 0) ? 2'd1 : 2'd3) || od1 !== m_data)
        $display("FAIL sparse_out i=%0d got=%0d/%h exp=%0d/%h", i, os1, od1,
                 (i % 2 == 0) ? 1 : 3, m_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] hs;
    logic [3:0] hd;
    v1 = 4'hF; d1 = 16'h5E3C; ordy1 = 1;
    #1;
    tick();
    hs = os1; hd = od1;
    ordy1 = 0;
    repeat (3) begin
      #1;
      total_cnt++;
      if (r1 !== 4'b0) $display("FAIL stall_ready got=%b exp=0000", r1);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ov1, os1, od1} !== {1'b1, hs, hd})
        $display("FAIL stall_hold got=%b/%0d/%h exp=1/%0d/%h", ov1, os1, od1,
                 hs, hd);
      else pass_cnt++;
    end
    ordy1 = 1;
    #1;
    total_cnt++;
    if (r1 !== exp_ready1() || r1 !== 4'(1 << ((hs + 1) % 4)))
      $display("FAIL release_ready got=%b exp=%b", r1, 4'(1 << ((hs + 1) % 4)));
    else pass_cnt++;
    tick();
    total_cnt++;
    if (os1 !== 2'(hs + 1)) $display("FAIL release_sel got=%0d exp=%0d", os1,
                                     2'(hs + 1));
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    ordy1 = 1; v1 = 4'b0100; d1 = 16'h0700;
    #1;
    total_cnt++;
    if ({ov1, r1} !== {1'b1, 4'b0100})
      $display("FAIL refill_ready got=%b/%b exp=1/0100", ov1, r1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({ov1, os1, od1} !== {1'b1, 2'd2, 4'h7})
      $display("FAIL refill_out got=%b/%0d/%h exp=1/2/7", ov1, os1, od1);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0] acc1;
    logic [2:0] acc0;
    acc1 = '0; acc0 = '0;
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      ordy0 = ($urandom_range(0, 3) != 0);
      ordy1 = ($urandom_range(0, 3) != 0);
      s0 = 2'($urandom_range(0, 3));
      for (int i = 0; i < N1; i++) begin
        if (!v1[i] || acc1[i]) begin
          v1[i] = ($urandom_range(0, 2) != 0);
          d1[i*4 +: 4] = 4'($urandom);
        end
      end
      for (int i = 0; i < N0; i++) begin
        if (!v0[i] || acc0[i]) begin
          v0[i] = ($urandom_range(0, 2) != 0);
          d0[i*3 +: 3] = 3'($urandom);
        end
      end
      #1;
      total_cnt++;
      if (r1 !== exp_ready1() || r0 !== exp_ready0())
        $display("FAIL rand_ready c=%0d got=%b/%b exp=%b/%b", c, r1, r0,
                 exp_ready1(), exp_ready0());
      else pass_cnt++;
      acc1 = r1 & v1;
      acc0 = r0 & v0;
      tick();
      total_cnt++;
      if ({ov1, od1, os1, ov0, od0, os0} !==
          {m_valid, m_data, m_sel, f_valid, f_data, f_sel})
        $display("FAIL rand_out c=%0d got=%b/%h/%0d %b/%h/%0d exp=%b/%h/%0d %b/%h/%0d",
                 c, ov1, od1, os1, ov0, od0, os0,
                 m_valid, m_data, m_sel, f_valid, f_data, f_sel);
      else pass_cnt++;
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_fixed_select();
    test_rr_fair();
    test_rr_sparse();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
